// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5..MaxDataLength data bits, none/even/odd parity, 1/2 stop); optional break detect via UART_RX_BREAK_DET_EN.
// Frame is presented one cycle after the last stop-bit majority point; a completing frame is dropped with sticky o_overrun while a held frame is unaccepted.
module uart_rx_cfg #(
    parameter int SystemClockFreq = 50_000_000,
    parameter int BaudRate        = 115200,
    parameter int MaxDataLength   = 9,
    parameter int SyncStages      = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx,
    input  logic [3:0]               i_cfg_data_len,
    input  logic                     i_cfg_parity_en,
    input  logic                     i_cfg_parity_even,
    input  logic                     i_cfg_two_stop,
    output logic [MaxDataLength-1:0] o_rx_data,
    output logic                     o_rx_valid,
    input  logic                     i_rx_ready,
    output logic                     o_parity_err,
    output logic                     o_frame_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                     o_break,
`endif
    output logic                     o_overrun,
    input  logic                     i_clr_overrun,
    output logic                     o_busy
);
    localparam int CPB   = SystemClockFreq / BaudRate;
    localparam int TENTH = CPB / 10;
    localparam int CW    = $clog2(CPB);
    localparam logic [CW-1:0] C_S0   = CW'(CPB / 2 - TENTH);
    localparam logic [CW-1:0] C_S1   = CW'(CPB / 2);
    localparam logic [CW-1:0] C_S2   = CW'(CPB / 2 + TENTH);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, FRAME_RECOVER
    } state_t;

    state_t                   state;
    logic [SyncStages-1:0]    sync_q;
    logic                     rx;
    logic [CW-1:0]            cnt;
    logic                     s0, s1, maj_q;
    logic [3:0]               bit_idx, len_q, len_in;
    logic                     par_en_q, par_even_q, two_stop_q;
    logic [MaxDataLength-1:0] shreg;
    logic                     par_acc, perr, ferr, done;
    logic                     maj, at_s2, boundary, last_stop, ferr_fin;
`ifdef UART_RX_BREAK_DET_EN
    logic                     any_one;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '1;
        else          sync_q <= {sync_q[SyncStages-2:0], i_rx};
    end
    assign rx = sync_q[SyncStages-1];

    // Majority is only meaningful at C_S2, where the third sample is the live rx.
    assign maj       = (s0 & s1) | (s0 & rx) | (s1 & rx);
    assign at_s2     = (cnt == C_S2);
    assign boundary  = (cnt == C_LAST);
    assign ferr_fin  = ferr | ~maj;
    assign last_stop = at_s2 && ((state == STOP1 && !two_stop_q) || state == STOP2);
    assign o_busy    = (state != IDLE);

    always_comb begin
        len_in = i_cfg_data_len;
        if (i_cfg_data_len < 4'd5 || i_cfg_data_len > 4'(MaxDataLength))
            len_in = 4'(MaxDataLength);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            maj_q      <= 1'b1;
            bit_idx    <= '0;
            len_q      <= 4'(MaxDataLength);
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            two_stop_q <= 1'b0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            done       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            any_one    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                if (cnt == C_S0) s0 <= rx;
                if (cnt == C_S1) s1 <= rx;
                if (at_s2)       maj_q <= maj;
                cnt <= boundary ? '0 : cnt + CW'(1);
            end
            case (state)
                IDLE: if (!rx) begin
                    state      <= START;
                    cnt        <= '0;
                    len_q      <= len_in;
                    par_en_q   <= i_cfg_parity_en;
                    par_even_q <= i_cfg_parity_even;
                    two_stop_q <= i_cfg_two_stop;
                    shreg      <= '0;
                    bit_idx    <= '0;
                    par_acc    <= 1'b0;
                    perr       <= 1'b0;
                    ferr       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    any_one    <= 1'b0;
`endif
                end
                START: begin
                    if (at_s2 && maj)  state <= IDLE;
                    else if (boundary) state <= DATA;
                end
                DATA: if (boundary) begin
                    shreg[bit_idx] <= maj_q;
                    par_acc        <= par_acc ^ maj_q;
`ifdef UART_RX_BREAK_DET_EN
                    any_one        <= any_one | maj_q;
`endif
                    if (bit_idx == len_q - 4'd1) state <= par_en_q ? PARITY : STOP1;
                    else                         bit_idx <= bit_idx + 4'd1;
                end
                PARITY: if (boundary) begin
                    perr  <= par_acc ^ maj_q ^ ~par_even_q;
`ifdef UART_RX_BREAK_DET_EN
                    any_one <= any_one | maj_q;
`endif
                    state <= STOP1;
                end
                STOP1, STOP2: begin
                    if (at_s2) begin
                        ferr <= ferr_fin;
`ifdef UART_RX_BREAK_DET_EN
                        any_one <= any_one | maj;
`endif
                    end
                    if (last_stop) begin
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= ferr_fin ? FRAME_RECOVER : IDLE;
                    end else if (boundary && state == STOP1) begin
                        state <= STOP2;
                    end
                end
                FRAME_RECOVER: begin
                    // Line must sit high for a full bit time before re-arming.
                    if (!rx)           cnt   <= '0;
                    else if (boundary) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            o_break      <= 1'b0;
`endif
        end else begin
            if (done && (!o_rx_valid || i_rx_ready)) begin
                o_rx_data    <= shreg;
                o_parity_err <= perr;
                o_frame_err  <= ferr;
                o_rx_valid   <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                o_break      <= ferr & ~any_one;
`endif
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
            if (done && o_rx_valid && !i_rx_ready) o_overrun <= 1'b1;
            else if (i_clr_overrun)                o_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed and randomized frames against a frame-level expectation queue.
module tb_uart_rx_cfg;
    localparam int CPB  = 50_000_000 / 115200;
    localparam int MAXW = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] cfg_len = 4'd8;
    logic       cfg_pen = 1'b0, cfg_peven = 1'b0, cfg_two = 1'b0;
    logic [8:0] rx_data;
    logic       rx_valid, perr, ferr, ovr, busy;
    logic       rx_ready = 1'b1;
    logic       clr = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk;
`endif

    always #5 clk = ~clk;

    uart_rx_cfg dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx),
        .i_cfg_data_len(cfg_len), .i_cfg_parity_en(cfg_pen),
        .i_cfg_parity_even(cfg_peven), .i_cfg_two_stop(cfg_two),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
        .o_parity_err(perr), .o_frame_err(ferr),
`ifdef UART_RX_BREAK_DET_EN
        .o_break(brk),
`endif
        .o_overrun(ovr), .i_clr_overrun(clr), .o_busy(busy)
    );

    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0, n_bad = 0, n_acc = 0, n_exp = 0;
    bit   prev_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic bit_time();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Reference: builds the line waveform and the expected delivered frame from the frame rules.
    task automatic send_frame(input logic [8:0] val, input int len_cfg, input bit pen,
                              input bit peven, input bit two, input int pbit,
                              input bit stop1, input bit stop2, input bit scramble);
        int         len;
        logic [8:0] d;
        bit         p;
        exp_t       e;
        len = (len_cfg < 5 || len_cfg > MAXW) ? MAXW : len_cfg;
        d   = val & 9'((1 << len) - 1);
        if (pbit < 0) p = peven ? ($countones(d) % 2) : 1 - ($countones(d) % 2);
        else          p = pbit[0];
        e.data = d;
        e.pe   = pen && ((($countones(d) + p) % 2) != (peven ? 0 : 1));
        e.fe   = !stop1 || (two && !stop2);
        e.bk   = (d == 0) && (!pen || !p) && !stop1 && (!two || !stop2);
        if (!(exp_q.size() > 0 && !rx_ready)) begin
            exp_q.push_back(e);
            n_exp++;
        end
        @(posedge clk); #1;
        cfg_len = 4'(len_cfg); cfg_pen = pen; cfg_peven = peven; cfg_two = two;
        @(posedge clk); #1;
        rx = 1'b0;
        bit_time();
        if (scramble) begin
            cfg_len = 4'($urandom); cfg_pen = 1'($urandom);
            cfg_peven = 1'($urandom); cfg_two = 1'($urandom);
        end
        for (int i = 0; i < len; i++) begin
            rx = d[i];
            bit_time();
        end
        if (pen) begin rx = p; bit_time(); end
        rx = stop1; bit_time();
        if (two) begin rx = stop2; bit_time(); end
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_acc) chk("valid_drop_after_accept", rx_valid, 1'b0);
            prev_acc = rx_valid && rx_ready;
            if (rx_valid && rx_ready) begin
                n_acc++;
                chk("frame_expected", (n_acc <= n_exp), 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rx_data", rx_data, mon_e.data);
                    chk("parity_err", perr, mon_e.pe);
                    chk("frame_err", ferr, mon_e.fe);
`ifdef UART_RX_BREAK_DET_EN
                    chk("break", brk, mon_e.bk);
`endif
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rx_valid, 0); chk("rst_data", rx_data, 0);
        chk("rst_perr", perr, 0);      chk("rst_ferr", ferr, 0);
        chk("rst_overrun", ovr, 0);    chk("rst_busy", busy, 0);
`ifdef UART_RX_BREAK_DET_EN
        chk("rst_break", brk, 0);
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;

        send_frame(9'h0A5, 8, 0, 0, 0, -1, 1, 1, 0);
        repeat (10) @(posedge clk);
        @(negedge clk); chk("a5_no_overrun", ovr, 0);

        send_frame(9'h041, 7, 1, 1, 1, -1, 1, 1, 0);
        send_frame(9'h041, 7, 1, 1, 1, 1, 1, 1, 0);

        send_frame(9'h03C, 8, 0, 0, 0, -1, 0, 1, 0);
        repeat (420) @(posedge clk);
        @(negedge clk); chk("recover_busy", busy, 1);
        repeat (25) @(posedge clk);
        @(negedge clk); chk("recover_done", busy, 0);
        send_frame(9'h055, 8, 0, 0, 0, -1, 1, 1, 0);

        @(posedge clk); #1; rx = 1'b0;
        repeat (100) @(posedge clk); #1; rx = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk); chk("glitch_idle", busy, 0); chk("glitch_no_valid", rx_valid, 0);
        send_frame(9'h081, 8, 0, 0, 0, -1, 1, 1, 0);

        @(posedge clk); #1; rx_ready = 1'b0;
        send_frame(9'h011, 8, 0, 0, 0, -1, 1, 1, 0);
        send_frame(9'h022, 8, 0, 0, 0, -1, 1, 1, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ovr_held_valid", rx_valid, 1); chk("ovr_held_data", rx_data, 9'h011);
        chk("ovr_set", ovr, 1);
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        @(negedge clk); chk("ovr_cleared", ovr, 0);
        @(posedge clk); #1; clr = 1'b1;
        fork
            send_frame(9'h033, 8, 0, 0, 0, -1, 1, 1, 0);
            begin
                for (int k = 0; k < 6000; k++) begin
                    @(negedge clk);
                    if (ovr) break;
                end
                clr = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ovr_set_wins", ovr, 1); chk("ovr_keeps_data", rx_data, 9'h011);
        @(posedge clk); #1; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); chk("ovr_drained", rx_valid, 0);
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;

        send_frame(9'h1FF, 9, 1, 0, 0, -1, 1, 1, 0);
        send_frame(9'h000, 9, 1, 0, 0, 0, 0, 1, 0);
        repeat (CPB + 12) @(posedge clk);
        @(negedge clk); chk("break_recovered", busy, 0);

        for (int r = 0; r < 3; r++) begin
            send_frame(9'($urandom), $urandom_range(3, 12), 1'($urandom), 1'($urandom),
                       1'($urandom), $urandom_range(0, 1), 1, 1, 1);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("frames_delivered", n_acc, n_exp);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("final_overrun", ovr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver; generational successor to the fixed-format receiver in the serial block.
- Frame format (data length 5..MaxDataLength, parity none/even/odd, 1 or 2 stop bits) is set by quasi-static config inputs, not parameters.
- Delivers each received frame with per-frame error flags over a valid/ready handshake into the RX FIFO or a consumer.
- Errors never lock up the receiver; an overrun flag is sticky until cleared.

Parameters:
SystemClockFreq, 50_000_000, i_clk frequency in Hz
BaudRate, 115200, line rate; CyclesPerBit = SystemClockFreq/BaudRate, TenthOfBit = CyclesPerBit/10 (integer division)
MaxDataLength, 9, width of o_rx_data; legal 5..9
SyncStages, 2, synchroniser flops on i_rx; legal 2..3

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  serial line, idle high, asynchronous
i_cfg_data_len  input  4  data bits per frame, 5..MaxDataLength; out-of-range values clamp to MaxDataLength
i_cfg_parity_en  input  1  1 = parity bit present
i_cfg_parity_even  input  1  1 = even parity, 0 = odd
i_cfg_two_stop  input  1  1 = two stop bits
o_rx_data  output  MaxDataLength  received data, LSB first on line, right-justified, unused MSBs 0
o_rx_valid  output  1  frame available
i_rx_ready  input  1  consumer accepts frame
o_parity_err  output  1  per-frame flag, qualified by o_rx_valid
o_frame_err  output  1  per-frame flag, qualified by o_rx_valid
o_overrun  output  1  sticky: frame lost because output was still held
i_clr_overrun  input  1  clears o_overrun
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; the state machine is in IDLE; the synchroniser flops are set to 1.
- i_rx passes through a SyncStages-deep synchroniser. All references to "rx" below mean the synchronised signal.
- Config is latched on the IDLE->START transition. Changing config mid-frame has no effect on the frame in progress.
- Bit clock counter runs 0..CyclesPerBit-1. It resets to 0 on IDLE->START. A bit boundary occurs when the counter equals CyclesPerBit-1.
- Sampling: rx is sampled at counts CPB/2-TenthOfBit, CPB/2 and CPB/2+TenthOfBit. The bit value is the majority of the three samples, valid from the third sample onward.
- States:
  - IDLE: rx==0 -> START.
  - START: at the majority point, a majority of 1 is a glitch -> IDLE (no output). Otherwise wait for the bit boundary -> DATA.
  - DATA: shift the majority value in at each boundary. After data_len bits -> PARITY if parity is enabled, else STOP1.
  - PARITY: compare the majority value with the computed parity. Even: XOR(data, p)==0. Odd: XOR(data, p)==1. Boundary -> STOP1.
  - STOP1: at the majority point, complete the frame. If two_stop -> STOP2 at the boundary, else go to IDLE immediately (early resync, half a bit early).
  - STOP2: checked identically to STOP1, then -> IDLE.
  - FRAME_RECOVER: entered instead of IDLE when a stop bit's majority is 0. Waits for rx==1 for one full bit time, then -> IDLE.
- Frame completion happens in the cycle after the last stop-bit majority point. On that cycle:
  - o_rx_data, o_parity_err and o_frame_err load.
  - o_rx_valid rises and holds until the cycle with o_rx_valid && i_rx_ready.
  - Data and flags are stable while valid.
- A frame error still delivers the data.
- Handshake: data, flags and valid are registered outputs. valid drops the cycle after acceptance, unless a new frame completes in that same cycle; then valid stays high with the new frame.
- Overrun: a frame completing while o_rx_valid && !i_rx_ready is discarded, the held frame is kept, and o_overrun is set. i_clr_overrun clears it; if a set and a clear occur in the same cycle, set wins.
- Reset mid-frame: everything returns to the reset state immediately, and any pending frame is lost.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined: adds output o_break (1 bit, reset 0). A break is a frame whose data bits, parity and stop samples are all 0. It is delivered as data 0 with o_frame_err=1 and o_break=1. o_break is qualified by o_rx_valid. FRAME_RECOVER then waits for rx to return high.
- Undefined: no o_break port; a break is reported as an ordinary frame error.

Test Plan:
- 8N1, 0xA5 at 115200 (CPB=434, samples at counts 174/217/260), ready tied high -> one valid pulse, data 0x0A5, both error flags 0, no overrun.
- 7E2 frame 0x41 with a correct parity bit, then a repeat with the parity bit flipped -> data 0x041 both times; parity_err 0 on the first frame, 1 on the second.
- 8N1 0x3C with the stop bit driven 0 -> data 0x03C, frame_err=1; the receiver stays in FRAME_RECOVER until rx is high for 434 cycles, then a following 0x55 is received cleanly.
- 100-cycle low glitch in idle -> no valid, state back to IDLE; a clean 0x81 sent after it is received correctly.
- Hold i_rx_ready=0 across frames 0x11 then 0x22 -> data stays 0x011, o_overrun=1. i_clr_overrun pulse clears it. A clear asserted in the same cycle as a new overrun leaves it at 1.
- 9O1 0x1FF with data_len=9; then with UART_RX_BREAK_DET_EN, a break of 12 bit times -> data 0, frame_err=1, o_break=1, single valid.
